// File: rtl/backprop_train_ctrl.sv
// Training sequencer for the 2-3-2 backprop net: walks a sample memory for N epochs, pulsing update per sample.
// Latency: inputs/targets valid the edge after start; update rises SETTLE_CYCLES+1 edges later; period SETTLE_CYCLES+2.
// Backpressure: none; start/ld_en are ignored while busy, abort forces IDLE on the next edge.
module backprop_train_ctrl #(
    parameter int DATA_W        = 32,
    parameter int NUM_SAMPLES   = 4,
    parameter int ADDR_W        = 2,
    parameter int SETTLE_CYCLES = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_in1,
    input  logic [DATA_W-1:0] ld_in2,
    input  logic [DATA_W-1:0] ld_t1,
    input  logic [DATA_W-1:0] ld_t2,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       epochs,
    input  logic [ADDR_W:0]   n_samples,
    input  logic [DATA_W-1:0] step_in,
    output logic [DATA_W-1:0] input_1,
    output logic [DATA_W-1:0] input_2,
    output logic [DATA_W-1:0] target_1,
    output logic [DATA_W-1:0] target_2,
    output logic [DATA_W-1:0] step,
    output logic              update,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sample_idx,
    output logic [15:0]       epoch_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [DATA_W-1:0] t1;
        logic [DATA_W-1:0] t2;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ONE_C       = CNT_W'(1);
    localparam logic [ADDR_W:0]   NSAMP_MAX   = (ADDR_W + 1)'(NUM_SAMPLES);
    localparam logic [ADDR_W:0]   ONE_N       = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);

    sample_t           r_mem [NUM_SAMPLES];
    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_settle_cnt;
    logic [15:0]       r_epochs;
    logic [ADDR_W:0]   r_n_samples;
    logic [DATA_W-1:0] r_in1, r_in2, r_t1, r_t2, r_step;
    logic              r_update, r_busy, r_done;
    logic [ADDR_W-1:0] r_sample_idx;
    logic [15:0]       r_epoch_cnt;

    logic              w_wr_en;
    logic              w_params_ok;
    logic              w_last_sample;
    logic              w_last_epoch;
    logic              w_start_ok, w_reject, w_next_sample, w_next_epoch, w_finish;
    logic              w_load;
    logic [ADDR_W-1:0] w_rd_addr;
    sample_t           w_wr_data;
    sample_t           w_rd_data;

    // Memory writes only land while idle; out-of-range addresses are dropped.
    assign w_wr_en   = ld_en && !r_busy && ({1'b0, ld_addr} < NSAMP_MAX);
    assign w_wr_data = '{in1: ld_in1, in2: ld_in2, t1: ld_t1, t2: ld_t2};

    assign w_params_ok   = (epochs != 16'd0) && (n_samples != '0) && (n_samples <= NSAMP_MAX);
    assign w_last_sample = (({1'b0, r_sample_idx} + ONE_N) == r_n_samples);
    assign w_last_epoch  = ((r_epoch_cnt + 16'd1) == r_epochs);
    assign w_load        = w_start_ok | w_next_sample | w_next_epoch;

    // Write-first read: a same-cycle write to the entry being fetched is forwarded.
    assign w_rd_data = (w_wr_en && (ld_addr == w_rd_addr)) ? w_wr_data : r_mem[w_rd_addr];

    // Next-state and per-edge control decode; abort overrides everything but reset.
    always_comb begin
        w_next_state  = r_state;
        w_rd_addr     = '0;
        w_start_ok    = 1'b0;
        w_reject      = 1'b0;
        w_next_sample = 1'b0;
        w_next_epoch  = 1'b0;
        w_finish      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (w_params_ok) begin
                        w_next_state = ST_LOAD;
                        w_start_ok   = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                w_next_state = abort ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (!w_last_sample) begin
                    w_next_state  = ST_LOAD;
                    w_next_sample = 1'b1;
                    w_rd_addr     = r_sample_idx + ONE_A;
                end else if (!w_last_epoch) begin
                    w_next_state = ST_LOAD;
                    w_next_epoch = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Counts cycles spent in SETTLE; restarts from 0 on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle_cnt <= '0;
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + ONE_C;
        end else begin
            r_settle_cnt <= '0;
        end
    end

    // Sample memory: cleared on reset, written from the load port while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[ld_addr] <= w_wr_data;
        end
    end

    // Registered outputs and run parameters; data only changes on LOAD entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in1        <= '0;
            r_in2        <= '0;
            r_t1         <= '0;
            r_t2         <= '0;
            r_step       <= '0;
            r_epochs     <= '0;
            r_n_samples  <= '0;
            r_update     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sample_idx <= '0;
            r_epoch_cnt  <= '0;
        end else begin
            r_update <= (w_next_state == ST_UPDATE);
            r_busy   <= (w_next_state != ST_IDLE);
            r_done   <= w_finish | w_reject;
            if (w_load) begin
                r_in1 <= w_rd_data.in1;
                r_in2 <= w_rd_data.in2;
                r_t1  <= w_rd_data.t1;
                r_t2  <= w_rd_data.t2;
            end
            if (w_start_ok) begin
                r_epochs     <= epochs;
                r_n_samples  <= n_samples;
                r_step       <= step_in;
                r_sample_idx <= '0;
                r_epoch_cnt  <= '0;
            end
            if (w_next_sample) begin
                r_sample_idx <= r_sample_idx + ONE_A;
            end
            if (w_next_epoch) begin
                r_sample_idx <= '0;
                r_epoch_cnt  <= r_epoch_cnt + 16'd1;
            end
            if (w_finish) begin
                r_epoch_cnt <= r_epoch_cnt + 16'd1;
            end
        end
    end

    assign input_1    = r_in1;
    assign input_2    = r_in2;
    assign target_1   = r_t1;
    assign target_2   = r_t2;
    assign step       = r_step;
    assign update     = r_update;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sample_idx = r_sample_idx;
    assign epoch_cnt  = r_epoch_cnt;

endmodule

// File: tb/tb_backprop_train_ctrl.sv
// Bench for backprop_train_ctrl: scoreboard of expected update pulses checked as the DUT issues them.
// Latency: checks sample outputs on the falling edge, half a cycle after the active edge.
// Backpressure: n/a; every wait is bounded by a cycle budget plus a global watchdog.
module tb_backprop_train_ctrl;

    localparam int DW     = 32;
    localparam int NS     = 4;
    localparam int AW     = 2;
    localparam int SC     = 10;
    localparam int PERIOD = SC + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_in1, ld_in2, ld_t1, ld_t2;
    logic          start, abort;
    logic [15:0]   epochs;
    logic [AW:0]   n_samples;
    logic [DW-1:0] step_in;
    logic [DW-1:0] input_1, input_2, target_1, target_2, step;
    logic          update, busy, done;
    logic [AW-1:0] sample_idx;
    logic [15:0]   epoch_cnt;

    backprop_train_ctrl #(
        .DATA_W(DW), .NUM_SAMPLES(NS), .ADDR_W(AW), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_in1(ld_in1), .ld_in2(ld_in2), .ld_t1(ld_t1), .ld_t2(ld_t2),
        .start(start), .abort(abort), .epochs(epochs), .n_samples(n_samples), .step_in(step_in),
        .input_1(input_1), .input_2(input_2), .target_1(target_1), .target_2(target_2),
        .step(step), .update(update), .busy(busy), .done(done),
        .sample_idx(sample_idx), .epoch_cnt(epoch_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] in1, in2, t1, t2;
    } smp_t;

    typedef struct {
        smp_t          s;
        logic [DW-1:0] stp;
        logic [AW-1:0] idx;
        logic [15:0]   ep;
        bit            gap_chk;
    } exp_t;

    smp_t m_mem [NS];
    exp_t sb_q[$];

    int n_checks     = 0;
    int n_errors     = 0;
    int n_upd        = 0;
    int last_upd_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, expv);
        end
    endtask

    // Pop the expected record for every update pulse and compare what the DUT presents.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && update === 1'b1) begin
            n_upd++;
            if (sb_q.size() == 0) begin
                chk("unexpected_update", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("upd_in1",  input_1,    e.s.in1);
                chk("upd_in2",  input_2,    e.s.in2);
                chk("upd_t1",   target_1,   e.s.t1);
                chk("upd_t2",   target_2,   e.s.t2);
                chk("upd_step", step,       e.stp);
                chk("upd_idx",  sample_idx, e.idx);
                chk("upd_ecnt", epoch_cnt,  e.ep);
                if (e.gap_chk) chk("upd_gap", cyc - last_upd_cyc, PERIOD);
            end
            last_upd_cyc = cyc;
        end
    end

    task automatic load_sample(input int a, input logic [DW-1:0] i1, input logic [DW-1:0] i2,
                               input logic [DW-1:0] t1, input logic [DW-1:0] t2);
        ld_en = 1'b1; ld_addr = AW'(a);
        ld_in1 = i1; ld_in2 = i2; ld_t1 = t1; ld_t2 = t2;
        m_mem[a] = '{in1: i1, in2: i2, t1: t1, t2: t2};
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Drive a one-cycle start; returns at the falling edge after E0 with that cycle number.
    task automatic start_run(input logic [15:0] ep, input logic [AW:0] ns, input logic [DW-1:0] stp,
                             input bit expect_upd, output int c0);
        exp_t e;
        epochs = ep; n_samples = ns; step_in = stp;
        if (expect_upd) begin
            for (int ei = 0; ei < int'(ep); ei++) begin
                for (int si = 0; si < int'(ns); si++) begin
                    e.s = m_mem[si]; e.stp = stp; e.idx = AW'(si); e.ep = 16'(ei);
                    e.gap_chk = !(ei == 0 && si == 0);
                    sb_q.push_back(e);
                end
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic end_run(input string tg, input logic [15:0] ep, input logic [DW-1:0] stp);
        chk({tg, "_sb_empty"}, sb_q.size(), 0);
        chk({tg, "_ecnt"}, epoch_cnt, ep);
        chk({tg, "_step"}, step, stp);
        chk({tg, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int u0;
        bit seen;
        reset = 1'b1; ld_en = 1'b0; ld_addr = '0;
        ld_in1 = '0; ld_in2 = '0; ld_t1 = '0; ld_t2 = '0;
        start = 1'b0; abort = 1'b0; epochs = '0; n_samples = '0; step_in = '0;
        for (int i = 0; i < NS; i++) m_mem[i] = '{default: '0};
        repeat (3) @(negedge clk);
        chk("rst_update", update, 1'b0);
        chk("rst_busy",   busy,   1'b0);
        chk("rst_done",   done,   1'b0);
        chk("rst_in1",    input_1, 0);
        chk("rst_step",   step,   0);
        chk("rst_idx",    sample_idx, 0);
        chk("rst_ecnt",   epoch_cnt, 0);
        reset = 1'b0;
        @(negedge clk);

        // T1: reset asserted between edges in the middle of SETTLE
        load_sample(0, 32'h0300_0000, 32'h0400_0000, 32'h0100_0000, 32'h0200_0000);
        start_run(16'd1, 3'd1, 32'h0010_0000, 1'b0, c0);
        chk("t1_busy_e0", busy, 1'b1);
        chk("t1_in1_e0",  input_1, 32'h0300_0000);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t1_update", update, 1'b0);
        chk("t1_busy",   busy,   1'b0);
        chk("t1_in1",    input_1, 0);
        chk("t1_done",   done,   1'b0);
        chk("t1_step",   step,   0);
        sb_q.delete();
        for (int i = 0; i < NS; i++) m_mem[i] = '{default: '0};
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t1_idle", busy, 1'b0);

        // Memory was cleared by reset: a run over mem[0] presents zeros
        start_run(16'd1, 3'd1, 32'h0000_0001, 1'b1, c0);
        chk("t1b_in1", input_1, 0);
        wait_done(PERIOD + 8);
        end_run("t1b", 16'd1, 32'h0000_0001);

        // T2: single sample, single epoch, exact edge timing
        load_sample(0, 32'h0800_0000, 32'h0500_0000, 32'h0100_0000, 32'h0000_0000);
        u0 = n_upd;
        start_run(16'd1, 3'd1, 32'h0019_9999, 1'b1, c0);
        chk("t2_in1_e0", input_1, 32'h0800_0000);
        chk("t2_step_e0", step, 32'h0019_9999);
        wait_done(PERIOD + 8);
        chk("t2_done_cyc", cyc - c0, PERIOD);
        chk("t2_upd_cyc", last_upd_cyc - c0, PERIOD - 1);
        chk("t2_nupd", n_upd - u0, 1);
        end_run("t2", 16'd1, 32'h0019_9999);
        @(negedge clk);
        chk("t2_done_width", done, 1'b0);

        // T3: four distinct samples, three epochs
        for (int i = 0; i < NS; i++)
            load_sample(i, 32'h0100_0000 * (i + 1), 32'h0010_0000 + 32'(i), 32'h00A0_0000 - 32'(i), 32'hF000_0000 + 32'(i * 7));
        u0 = n_upd;
        start_run(16'd3, 3'd4, 32'h0002_0000, 1'b1, c0);
        wait_done(3 * 4 * PERIOD + 10);
        chk("t3_nupd", n_upd - u0, 12);
        end_run("t3", 16'd3, 32'h0002_0000);

        // T4: invalid starts give a done pulse and never leave IDLE
        u0 = n_upd;
        start_run(16'd0, 3'd4, 32'h0000_1111, 1'b0, c0);
        chk("t4a_done", done, 1'b1);
        chk("t4a_busy", busy, 1'b0);
        @(negedge clk);
        chk("t4a_done_width", done, 1'b0);
        start_run(16'd2, 3'd0, 32'h0000_2222, 1'b0, c0);
        chk("t4b_done", done, 1'b1);
        chk("t4b_busy", busy, 1'b0);
        start_run(16'd2, 3'd5, 32'h0000_3333, 1'b0, c0);
        chk("t4c_done", done, 1'b1);
        chk("t4c_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_nupd", n_upd - u0, 0);

        // Abort together with start in IDLE: stays idle, no done
        abort = 1'b1;
        start_run(16'd1, 3'd1, 32'h0000_4444, 1'b0, c0);
        abort = 1'b0;
        chk("t4d_busy", busy, 1'b0);
        chk("t4d_done", done, 1'b0);

        // T5: abort during the fifth SETTLE cycle
        u0 = n_upd;
        start_run(16'd1, 3'd4, 32'h0000_5555, 1'b0, c0);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_busy",   busy,   1'b0);
        chk("t5_update", update, 1'b0);
        chk("t5_done",   done,   1'b0);
        chk("t5_in1_hold", input_1, m_mem[0].in1);
        seen = 1'b0;
        repeat (2 * PERIOD) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("t5_no_done", seen, 1'b0);
        chk("t5_nupd", n_upd - u0, 0);
        start_run(16'd1, 3'd2, 32'h0000_6666, 1'b1, c0);
        wait_done(2 * PERIOD + 8);
        end_run("t5b", 16'd1, 32'h0000_6666);

        // T6: load and start while busy are ignored; mid-run parameter changes have no effect
        start_run(16'd1, 3'd2, 32'h0000_7777, 1'b1, c0);
        repeat (3) @(negedge clk);
        ld_en = 1'b1; ld_addr = '0;
        ld_in1 = 32'hDEAD_BEEF; ld_in2 = 32'hDEAD_BEEF; ld_t1 = 32'hDEAD_BEEF; ld_t2 = 32'hDEAD_BEEF;
        start = 1'b1; epochs = 16'd7; n_samples = 3'd1; step_in = 32'h0;
        @(negedge clk);
        ld_en = 1'b0; start = 1'b0;
        wait_done(2 * PERIOD + 8);
        end_run("t6", 16'd1, 32'h0000_7777);
        start_run(16'd1, 3'd1, 32'h0000_8888, 1'b1, c0);
        chk("t6_mem0_kept", input_1, m_mem[0].in1);
        wait_done(PERIOD + 8);
        end_run("t6b", 16'd1, 32'h0000_8888);

        // Write to entry 0 on the start edge is seen by the first sample
        ld_en = 1'b1; ld_addr = '0;
        ld_in1 = 32'h0ABC_0000; ld_in2 = 32'h0123_4567; ld_t1 = 32'h0076_5432; ld_t2 = 32'h0011_2233;
        m_mem[0] = '{in1: 32'h0ABC_0000, in2: 32'h0123_4567, t1: 32'h0076_5432, t2: 32'h0011_2233};
        start_run(16'd2, 3'd1, 32'h0000_9999, 1'b1, c0);
        ld_en = 1'b0;
        chk("t7_wf_in1", input_1, 32'h0ABC_0000);
        wait_done(2 * PERIOD + 8);
        end_run("t7", 16'd2, 32'h0000_9999);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
